// File: rtl/can_pkg.sv
// Shared CAN node definitions: identifier width, DLC limit, scheduler state
// encoding and flat-bus slice helpers used by the transmit scheduler.
package can_pkg;

    localparam int CAN_ID_WIDTH = 11;
    localparam int CAN_DLC_MAX  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_BACKOFF = 2'd3
    } can_state_t;

    // Lowest bit of slice i in a flat bus of width-w fields.
    function automatic int flat_lo(input int i, input int w);
        return i * w;
    endfunction

    function automatic logic [3:0] clamp_dlc(input logic [3:0] dlc);
        return (dlc > 4'(CAN_DLC_MAX)) ? 4'(CAN_DLC_MAX) : dlc;
    endfunction

endpackage

// File: rtl/can_prio_select.sv
// Combinational CAN priority finder: picks the valid requester with the
// lowest identifier; equal identifiers resolve to the lower index.
module can_prio_select
    import can_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = CAN_ID_WIDTH
) (
    input  logic [NUM_REQ-1:0]          valid,
    input  logic [NUM_REQ*ID_WIDTH-1:0] ids,
    output logic [$clog2(NUM_REQ)-1:0]  sel,
    output logic                        any_valid
);

    localparam int SEL_W = $clog2(NUM_REQ);

    logic [ID_WIDTH-1:0] best_id;

    // Strict less-than keeps the earlier (lower) index on identifier ties.
    always_comb begin
        sel       = '0;
        any_valid = 1'b0;
        best_id   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (valid[i] && (!any_valid || (ids[flat_lo(i, ID_WIDTH) +: ID_WIDTH] < best_id))) begin
                sel       = SEL_W'(i);
                best_id   = ids[flat_lo(i, ID_WIDTH) +: ID_WIDTH];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/can_tx_scheduler.sv
// Shares one CAN transmit engine among NUM_REQ requesters in bus-priority
// order, with per-requester retry limits, inter-frame spacing and a watchdog.
module can_tx_scheduler
    import can_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_WIDTH       = CAN_ID_WIDTH,
    parameter int RETRY_LIMIT    = 8,
    parameter int IFS_CYCLES     = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        can_clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ID_WIDTH-1:0] req_id,
    input  logic [NUM_REQ*4-1:0]        req_dlc,
    input  logic [NUM_REQ*64-1:0]       req_data,
    output logic [NUM_REQ-1:0]          req_done,
    output logic [NUM_REQ-1:0]          req_fail,
    output logic                        busy,
    output logic                        tx_start,
    output logic [ID_WIDTH-1:0]         tx_id,
    output logic [3:0]                  tx_dlc,
    output logic [63:0]                 tx_data,
    input  logic                        tx_ok,
    input  logic                        tx_arb_lost,
    input  logic                        tx_error,
    input  logic                        bus_idle
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int IFS_W = $clog2(IFS_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    can_state_t       state, state_next;
    logic [SEL_W-1:0] sel, win_sel;
    logic             win_any;
    logic [3:0]       retry [NUM_REQ];
    logic [3:0]       retry_inc;
    logic [IFS_W-1:0] ifs_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             start_sel, timeout, fail_hit, ifs_done, err_seen;

    can_prio_select #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_prio (
        .valid     (req_valid),
        .ids       (req_id),
        .sel       (win_sel),
        .any_valid (win_any)
    );

    // A done/fail pulse in flight blocks selection so the finished requester
    // has one cycle to withdraw before the next arbitration.
    assign start_sel = win_any && bus_idle && !(|req_done) && !(|req_fail);
    assign timeout   = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign err_seen  = tx_error || timeout;
    assign retry_inc = (retry[sel] >= 4'(RETRY_LIMIT)) ? 4'(RETRY_LIMIT) : retry[sel] + 4'd1;
    assign fail_hit  = (retry_inc == 4'(RETRY_LIMIT));
    assign ifs_done  = bus_idle && (ifs_cnt == IFS_W'(IFS_CYCLES - 1));

    always_ff @(posedge can_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start_sel) begin
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tx_start   = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_ok) begin
                    state_next = ST_IDLE;
                end else if (err_seen) begin
                    state_next = fail_hit ? ST_IDLE : ST_BACKOFF;
                end else if (tx_arb_lost) begin
                    state_next = ST_BACKOFF;
                end
            end
            ST_BACKOFF: begin
                if (ifs_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Frame latch, response handling and the IFS/watchdog counters.
    always_ff @(posedge can_clk or negedge rst_n) begin
        if (!rst_n) begin
            sel      <= '0;
            tx_id    <= '0;
            tx_dlc   <= '0;
            tx_data  <= '0;
            req_done <= '0;
            req_fail <= '0;
            ifs_cnt  <= '0;
            to_cnt   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                retry[i] <= '0;
            end
        end else begin
            req_done <= '0;
            req_fail <= '0;
            case (state)
                ST_IDLE: begin
                    if (start_sel) begin
                        sel     <= win_sel;
                        tx_id   <= req_id[flat_lo(int'(win_sel), ID_WIDTH) +: ID_WIDTH];
                        tx_dlc  <= clamp_dlc(req_dlc[flat_lo(int'(win_sel), 4) +: 4]);
                        tx_data <= req_data[flat_lo(int'(win_sel), 64) +: 64];
                    end
                end
                ST_LAUNCH: begin
                    to_cnt <= '0;
                end
                ST_WAIT: begin
                    if (tx_ok) begin
                        req_done[sel] <= 1'b1;
                        retry[sel]    <= '0;
                    end else if (err_seen) begin
                        ifs_cnt <= '0;
                        if (fail_hit) begin
                            req_fail[sel] <= 1'b1;
                            retry[sel]    <= '0;
                        end else begin
                            retry[sel] <= retry_inc;
                        end
                    end else if (tx_arb_lost) begin
                        ifs_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_BACKOFF: begin
                    if (!bus_idle || ifs_done) begin
                        ifs_cnt <= '0;
                    end else begin
                        ifs_cnt <= ifs_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
